// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port data memory (memory_main) between the fetch port
//   and the data (load/store) port. Only one access is in flight at a time.
//   The data port normally has priority. After MAX_STREAK consecutive data
//   grants while fetch is waiting, fetch is granted next.
//
// Ports
//   clock, resetn              : rising-edge clock, synchronous active-low reset
//   if_req/if_addr             : fetch read request and address
//   if_gnt/if_rvalid/if_rdata  : fetch accept pulse, read-data pulse, read data
//   d_req/d_we/d_addr/d_wdata  : data-port request, write enable, address, write data
//   d_gnt/d_rvalid/d_rdata     : data accept pulse (completion for writes),
//                                read-data pulse, read data
//   ram_addr/ram_data/ram_wren : drive memory_main addr/data/wr_en
//   ram_q                      : memory_main read data
//   busy                       : a read is in flight
module mem_port_arbiter #(
  parameter int WIDTH       = 20,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STREAK  = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_data,
  output logic             ram_wren,
  input  logic [WIDTH-1:0] ram_q,
  output logic             busy
);

  localparam int LW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q;
  logic [LW-1:0]    lat_cnt_q;
  logic [SW-1:0]    streak_q;
  logic             owner_q;      // 0: fetch, 1: data port
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] if_rdata_q;
  logic [WIDTH-1:0] d_rdata_q;

  logic idle_ok;
  logic at_max;
  logic d_win;
  logic f_win;
  logic ret;

  // Arbitration only happens in IDLE and out of reset, so reset suppresses
  // any combinational grant even while requests are held high.
  assign idle_ok = resetn && (state_q == IDLE);
  assign at_max  = (streak_q == SW'(MAX_STREAK));
  assign d_win   = idle_ok && d_req && !(if_req && at_max);
  assign f_win   = idle_ok && if_req && !d_win;

  // Return cycle: last WAIT cycle. Gated by resetn so a read interrupted by
  // reset never reports data.
  assign ret = resetn && (state_q == WAIT) && (lat_cnt_q == LW'(1));

  assign if_gnt    = f_win;
  assign d_gnt     = d_win;
  assign ram_wren  = d_win && d_we;
  assign ram_addr  = d_win ? d_addr : (f_win ? if_addr : addr_q);
  assign ram_data  = ram_wren ? d_wdata : data_q;
  assign busy      = (state_q == WAIT);
  assign if_rvalid = ret && !owner_q;
  assign d_rvalid  = ret && owner_q;
  // Read data passes through in the return cycle, then the captured copy holds.
  assign if_rdata  = if_rvalid ? ram_q : if_rdata_q;
  assign d_rdata   = d_rvalid ? ram_q : d_rdata_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      streak_q   <= '0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_win || f_win) begin
            addr_q <= ram_addr;
            if (ram_wren) begin
              // Writes complete at this edge; stay IDLE for the next access.
              data_q <= d_wdata;
            end else begin
              owner_q   <= d_win;
              lat_cnt_q <= LW'(MEM_LATENCY);
              state_q   <= WAIT;
            end
          end
          // Streak counts data grants made while fetch was kept waiting.
          if (f_win || !if_req) begin
            streak_q <= '0;
          end else if (d_win && (streak_q < SW'(MAX_STREAK))) begin
            streak_q <= streak_q + SW'(1);
          end
        end
        WAIT: begin
          lat_cnt_q <= lat_cnt_q - LW'(1);
          if (ret) begin
            state_q <= IDLE;
            if (owner_q) d_rdata_q  <= ram_q;
            else         if_rdata_q <= ram_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares the single-port data memory between two requesters. The fetch port serves instruction fetch; the data port serves the memory-access stage for loads and stores. Sits between the pipeline stages and memory_main, driving its address, write data and write enable, and returning read data after the memory's registered latency. One access is in flight at a time, with starvation-bounded priority for the data port.

Parameters:
WIDTH, 20, data and address width (matches the 20-bit datapath)
MEM_LATENCY, 1, cycles from address issue to valid memory q output; must be >= 1
MAX_STREAK, 3, max consecutive data-port grants while fetch is waiting; must be >= 1

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  synchronous active-low reset
if_req  input  1  fetch read request
if_addr  input  WIDTH  fetch address
if_gnt  output  1  fetch request accepted (1-cycle pulse)
if_rvalid  output  1  fetch read data valid (1-cycle pulse)
if_rdata  output  WIDTH  fetch read data
d_req  input  1  data-port request
d_we  input  1  data-port write (1) / read (0)
d_addr  input  WIDTH  data-port address
d_wdata  input  WIDTH  data-port write data
d_gnt  output  1  data request accepted (1-cycle pulse); for writes this is completion
d_rvalid  output  1  data-port read data valid (1-cycle pulse)
d_rdata  output  WIDTH  data-port read data
ram_addr  output  WIDTH  to memory_main addr
ram_data  output  WIDTH  to memory_main data
ram_wren  output  1  to memory_main wr_en
ram_q  input  WIDTH  from memory_main q
busy  output  1  read in flight (state WAIT)

Behaviour:
- Clock and reset: single clock, clock; resetn synchronous active-low, sampled on the rising edge.
- Reset values:
  - state=IDLE; lat_cnt=0; streak=0; owner=FETCH.
  - All gnt/rvalid/ram_wren/busy = 0.
  - ram_addr, ram_data, if_rdata, d_rdata = 0.
- FSM: IDLE, WAIT.
- IDLE, arbitration (combinational, same cycle):
  - Only one req high: that requester wins.
  - Both high: data port wins unless streak == MAX_STREAK, then fetch wins.
  - Winner's gnt is high this cycle; ram_addr = winner addr this cycle.
  - ram_wren = 1 only when the data port wins with d_we=1; ram_data = d_wdata that cycle.
- Writes:
  - Complete at the issue edge; d_gnt is the completion.
  - FSM stays IDLE, so the next access can issue the following cycle.
  - A req still high after gnt is a new request.
- Reads:
  - On the issue edge: owner := winner; lat_cnt := MEM_LATENCY; go to WAIT.
  - Requester may drop req after gnt.
- WAIT:
  - No grants; busy=1; ram_wren=0; ram_addr holds the last issued address (registered copy).
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt == 1: owner's rvalid=1 and owner's rdata = ram_q (combinational pass-through); next state IDLE.
  - Latency: gnt at cycle T → rvalid at cycle T+MEM_LATENCY.
- rdata outputs: after rvalid, a registered copy holds the last returned value; the non-owner's rdata is unchanged.
- Streak counter:
  - +1 (saturating at MAX_STREAK) on a data grant while if_req=1.
  - Cleared on any fetch grant, or in any IDLE cycle with if_req=0.
- Simultaneous events:
  - A request arriving during WAIT waits; it is evaluated in the IDLE cycle after rvalid.
  - No issue occurs in the rvalid cycle.
- Reset mid-operation: an in-flight read is dropped with no rvalid. All state returns to reset values on the next edge.
- Address/data are not modified; no alignment or width conversion is performed.

Test Plan:
- Reset: resetn=0 for 2 cycles with both reqs high → all gnt/rvalid/ram_wren/busy = 0, ram_addr = 0. After release, d_gnt in the first IDLE cycle.
- Single fetch read: if_req=1, if_addr=0x00010, MEM_LATENCY=1, ram_q=0xABCDE the next cycle → if_gnt at T, busy and if_rvalid at T+1 with if_rdata=0xABCDE, d_rvalid=0.
- Data write then read: d_we=1, d_addr=0x00020, d_wdata=0x12345 → d_gnt and ram_wren same cycle, busy stays 0. Then d_we=0 same address → d_rvalid one cycle later with d_rdata=0x12345 (memory model).
- Starvation bound: both reqs held high, all data ops reads, MAX_STREAK=3 → grant order D,D,D,F,D,D,D,F; no two grants closer than 2 cycles.
- Latency parameter: MEM_LATENCY=3, fetch read → rvalid exactly 3 cycles after gnt. A d_req raised in WAIT is granted 1 cycle after rvalid.
- Reset mid-read: resetn=0 on the cycle after d_gnt (read) → no d_rvalid ever asserted, busy=0 after the edge, next request serviced normally.
